// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and step encodings for counters and CDC FIFO pointer logic.
// Helpers operate on a fixed 32-bit word; callers zero-extend and truncate to their own width.
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // Kind of step taken by the counter on an edge.
   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_INC  = 2'd1,
      STEP_DEC  = 2'd2,
      STEP_LOAD = 2'd3
   } step_e;

   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Zero-extended upper bits contribute nothing to the running XOR.
   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next-state logic for the up/down Gray counter: load, count, wrap or saturate.
module gray_step
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int SATURATE   = 0
) (
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   output logic [DATA_WIDTH-1:0] b_nxt,
   output logic [DATA_WIDTH-1:0] g_nxt,
   output logic                  wrap_nxt
);

   localparam logic [DATA_WIDTH-1:0] MAX = '1;

   step_e op;
   logic  at_edge;

   // At the boundary in the current direction, the next step either wraps or is suppressed.
   assign at_edge = up ? (b == MAX) : (b == '0);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      op       = STEP_HOLD;
      b_nxt    = b;
      wrap_nxt = 1'b0;

      if (load) begin
         op = STEP_LOAD;
      end else if (en && !(at_edge && (SATURATE != 0))) begin
         op = up ? STEP_INC : STEP_DEC;
      end

      case (op)
         STEP_LOAD: b_nxt = load_val;
         STEP_INC:  b_nxt = b + DATA_WIDTH'(1);
         STEP_DEC:  b_nxt = b - DATA_WIDTH'(1);
         default:   b_nxt = b;
      endcase

      wrap_nxt = ((op == STEP_INC) || (op == STEP_DEC)) && at_edge;
      g_nxt    = DATA_WIDTH'(bin2gray(gray_word_t'(b_nxt)));
   end

endmodule

// File: rtl/gray_updn_cnt.sv
// Parametrised up/down Gray counter with load, wrap/saturate modes and registered Gray/binary outputs.
// gray_out is driven straight from flops so it can be synchronised into another clock domain.
module gray_updn_cnt
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int SATURATE   = 0
) (
   input  logic                  i_clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   output logic [DATA_WIDTH-1:0] gray_out,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic                  tc,
   output logic                  wrap
);

   localparam logic [DATA_WIDTH-1:0] MAX = '1;

   logic [DATA_WIDTH-1:0] b_nxt;
   logic [DATA_WIDTH-1:0] g_nxt;
   logic                  wrap_nxt;

   gray_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
   ) u_step (
      .b        (bin_out),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .b_nxt    (b_nxt),
      .g_nxt    (g_nxt),
      .wrap_nxt (wrap_nxt)
   );

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         bin_out  <= '0;
         gray_out <= '0;
         wrap     <= 1'b0;
      end else begin
         // NOTE: non-blocking so all three registers update from the same pre-edge state.
         bin_out  <= b_nxt;
         gray_out <= g_nxt;
         wrap     <= wrap_nxt;
      end
   end

   // Terminal count follows the live direction input, not a registered copy.
   assign tc = up ? (bin_out == MAX) : (bin_out == '0);

endmodule

// File: tb/tb_gray_updn_cnt.sv
// Scoreboard bench: four counter instances (4-bit wrap, 4-bit saturate, 2-bit, 8-bit) share stimulus;
// a driver pushes model expectations per edge and a monitor pops and compares after each edge.
module tb_gray_updn_cnt;

   logic       i_clk = 1'b0;
   logic       rst   = 1'b1;
   logic       en    = 1'b0;
   logic       up    = 1'b1;
   logic       load  = 1'b0;
   logic [7:0] load_val = '0;

   logic [3:0] g0, b0, g1, b1;
   logic [1:0] g2, b2;
   logic [7:0] g3, b3;
   logic [3:0] tc_v, wrap_v;

   logic [7:0] lg [4];
   logic [7:0] lb [4];

   localparam int K_HOLD = 0;
   localparam int K_STEP = 1;
   localparam int K_LOAD = 2;

   typedef struct packed {
      logic [3:0][7:0] b;
      logic [3:0][7:0] g;
      logic [3:0]      w;
      logic [3:0][1:0] kind;
   } exp_t;

   exp_t       sb_q [$];
   int         model_b [4];
   logic [7:0] prev_g [4];
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 i_clk = ~i_clk;

   gray_updn_cnt #(.DATA_WIDTH(4), .SATURATE(0)) u_w4 (
      .i_clk(i_clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
      .gray_out(g0), .bin_out(b0), .tc(tc_v[0]), .wrap(wrap_v[0]));
   gray_updn_cnt #(.DATA_WIDTH(4), .SATURATE(1)) u_s4 (
      .i_clk(i_clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
      .gray_out(g1), .bin_out(b1), .tc(tc_v[1]), .wrap(wrap_v[1]));
   gray_updn_cnt #(.DATA_WIDTH(2), .SATURATE(0)) u_w2 (
      .i_clk(i_clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[1:0]),
      .gray_out(g2), .bin_out(b2), .tc(tc_v[2]), .wrap(wrap_v[2]));
   gray_updn_cnt #(.DATA_WIDTH(8), .SATURATE(0)) u_w8 (
      .i_clk(i_clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .gray_out(g3), .bin_out(b3), .tc(tc_v[3]), .wrap(wrap_v[3]));

   always_comb begin
      lg[0] = {4'b0, g0}; lb[0] = {4'b0, b0};
      lg[1] = {4'b0, g1}; lb[1] = {4'b0, b1};
      lg[2] = {6'b0, g2}; lb[2] = {6'b0, b2};
      lg[3] = g3;         lb[3] = b3;
   end

   function automatic int lane_w(input int k);
      case (k)
         2:       return 2;
         3:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int lane_max(input int k);
      return (1 << lane_w(k)) - 1;
   endfunction

   // Gray to binary by running XOR from the most significant bit down.
   function automatic logic [7:0] ref_gray2bin(input logic [7:0] g);
      logic [7:0] r;
      r[7] = g[7];
      for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ g[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Apply one cycle of stimulus at the falling edge and queue what each lane must show after the edge.
   task automatic drive(input logic e, input logic u, input logic l, input logic [7:0] v);
      exp_t x;
      int   nb, mx, kd;
      logic wr;
      @(negedge i_clk);
      en = e; up = u; load = l; load_val = v;
      x = '0;
      for (int k = 0; k < 4; k++) begin
         mx = lane_max(k);
         nb = model_b[k];
         kd = K_HOLD;
         wr = 1'b0;
         if (l) begin
            nb = int'(v) & mx;
            kd = K_LOAD;
         end else if (e) begin
            nb = u ? model_b[k] + 1 : model_b[k] - 1;
            if (nb > mx || nb < 0) begin
               if (k == 1) begin
                  nb = model_b[k];
               end else begin
                  nb = (nb < 0) ? mx : 0;
                  wr = 1'b1;
                  kd = K_STEP;
               end
            end else begin
               kd = K_STEP;
            end
         end
         model_b[k] = nb;
         x.b[k]    = 8'(nb);
         x.g[k]    = 8'(nb ^ (nb >> 1));
         x.w[k]    = wr;
         x.kind[k] = 2'(kd);
      end
      sb_q.push_back(x);
   endtask

   // Monitor: compare every lane one time unit after each rising edge that has a queued expectation.
   initial begin
      exp_t       x;
      logic       exp_tc;
      logic [7:0] eb;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
               eb = x.b[k];
               exp_tc = up ? (int'(eb) == lane_max(k)) : (eb == 8'd0);
               check($sformatf("lane%0d bin_out", k), 32'(lb[k]), 32'(eb));
               check($sformatf("lane%0d gray_out", k), 32'(lg[k]), 32'(x.g[k]));
               check($sformatf("lane%0d wrap", k), 32'(wrap_v[k]), 32'(x.w[k]));
               check($sformatf("lane%0d tc", k), 32'(tc_v[k]), 32'(exp_tc));
               check($sformatf("lane%0d gray2bin", k), 32'(ref_gray2bin(lg[k])), 32'(lb[k]));
               if (int'(x.kind[k]) == K_STEP)
                  check($sformatf("lane%0d step bits changed", k), 32'($countones(lg[k] ^ prev_g[k])), 32'd1);
               else if (int'(x.kind[k]) == K_HOLD)
                  check($sformatf("lane%0d hold bits changed", k), 32'($countones(lg[k] ^ prev_g[k])), 32'd0);
               prev_g[k] = lg[k];
            end
         end
      end
   end

   // Pulse reset between clock edges and confirm outputs clear without an edge and stay clear.
   task automatic async_reset();
      @(negedge i_clk);
      en = 1'b1; up = 1'b1; load = 1'b0;
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("lane%0d async rst bin", k), 32'(lb[k]), 32'd0);
         check($sformatf("lane%0d async rst gray", k), 32'(lg[k]), 32'd0);
         check($sformatf("lane%0d async rst wrap", k), 32'(wrap_v[k]), 32'd0);
      end
      check("rst tc up=1", 32'(tc_v[0]), 32'd0);
      up = 1'b0;
      #1 check("rst tc up=0", 32'(tc_v[0]), 32'd1);
      @(posedge i_clk);
      #1;
      check("rst held bin", 32'(lb[3]), 32'd0);
      check("rst held gray", 32'(lg[0]), 32'd0);
      @(negedge i_clk);
      rst = 1'b0; en = 1'b0; up = 1'b1;
      for (int k = 0; k < 4; k++) begin
         model_b[k] = 0;
         prev_g[k]  = 8'd0;
      end
   endtask

   initial begin
      logic [3:0] fr_tab [17];
      fr_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      for (int k = 0; k < 4; k++) begin
         model_b[k] = 0;
         prev_g[k]  = 8'd0;
      end
      #1;
      check("power-on rst gray", 32'(lg[0]), 32'd0);
      check("power-on rst wrap", 32'(wrap_v[0]), 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      rst = 1'b0;

      // Free-run up from reset through the full 4-bit sequence and back to zero.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'h00);
         @(posedge i_clk);
         #2 check($sformatf("free-run gray step %0d", i), 32'(g0), 32'(fr_tab[i]));
      end

      // Down from reset: wraps 0 -> MAX, then continues down.
      async_reset();
      repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Saturate: load E then push up past MAX; load 0 then push down.
      drive(1'b0, 1'b1, 1'b1, 8'hFE);
      repeat (3) drive(1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Load wins over enable, then a normal step.
      drive(1'b1, 1'b1, 1'b1, 8'h05);
      drive(1'b1, 1'b1, 1'b0, 8'h00);

      // Enable gating at 3, then direction flips every cycle.
      drive(1'b0, 1'b0, 1'b1, 8'h03);
      repeat (5) drive(1'b0, 1'b1, 1'b0, 8'h00);
      repeat (2) begin
         drive(1'b1, 1'b1, 1'b0, 8'h00);
         drive(1'b1, 1'b0, 1'b0, 8'h00);
      end

      // Wrap back and forth across the boundary.
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      repeat (3) begin
         drive(1'b1, 1'b0, 1'b0, 8'h00);
         drive(1'b1, 1'b1, 1'b0, 8'h00);
      end

      // Reset arriving mid-count at A.
      drive(1'b0, 1'b1, 1'b1, 8'h0A);
      async_reset();

      // Full up and down sweep, covering every 8-bit value in both directions.
      repeat (257) drive(1'b1, 1'b1, 1'b0, 8'h00);
      repeat (257) drive(1'b1, 1'b0, 1'b0, 8'h00);

      // Random traffic with loads biased toward the boundaries.
      repeat (600) begin
         logic [7:0] v;
         v = ($urandom_range(0, 1) == 1) ? {8{1'($urandom_range(0, 1))}} ^ 8'($urandom_range(0, 1))
                                         : 8'($urandom);
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0), v);
      end

      @(negedge i_clk);
      en = 1'b0; load = 1'b0;
      repeat (2) @(posedge i_clk);
      #2 check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
